fetch_unit: RTL and testbench

Instruction-fetch stage feeding the decode stage's instr/valid inputs through the IF/ID pipeline register.
- Owns the PC and issues word reads to a variable-latency instruction memory/cache.
- Absorbs decode back-pressure with a one-entry skid buffer.
- Squashes wrong-path fetches on redirect and stops fetching after HALT.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_skid_buf.sv | 40 ++++
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned PcWidth = 16;

   localparam logic [PcWidth-1:0] NopInstr = 16'h0800;
   localparam logic [4:0]         HaltOpc  = 5'b00000;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StWait   = 2'd1,
      StDrain  = 2'd2,
      StHalted = 2'd3
   } fetch_state_e;

   // Instruction memory is word addressed in 16-bit units; bit 0 is never driven.
   function automatic logic [PcWidth-1:0] word_align(input logic [PcWidth-1:0] a);
      return a & ~{{(PcWidth-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pcPlus2} holding buffer that absorbs a fetched word while decode stalls.
module fetch_skid_buf import fetch_pkg::*; (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               unload_i,
   input  logic               clear_i,
   input  logic [PcWidth-1:0] instr_i,
   input  logic [PcWidth-1:0] pc_plus2_i,
   output logic               full_o,
   output logic [PcWidth-1:0] instr_o,
   output logic [PcWidth-1:0] pc_plus2_o
);

   logic               full_q;
   logic [PcWidth-1:0] instr_q;
   logic [PcWidth-1:0] pc_plus2_q;

   // Clear (redirect) beats load, load beats unload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q     <= 1'b0;
         instr_q    <= NopInstr;
         pc_plus2_q <= '0;
      end else if (clear_i) begin
         full_q <= 1'b0;
      end else if (load_i) begin
         full_q     <= 1'b1;
         instr_q    <= instr_i;
         pc_plus2_q <= pc_plus2_i;
      end else if (unload_i) begin
         full_q <= 1'b0;
      end
   end

   assign full_o     = full_q;
   assign instr_o    = instr_q;
   assign pc_plus2_o = pc_plus2_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues reads to a variable-latency instruction memory,
// and fills the IF/ID register through a one-entry skid buffer.
// Optional FETCH_PERF_CNT_EN adds saturating fetched-word and decode-stall counters.
module fetch_unit import fetch_pkg::*; #(
   parameter logic [PcWidth-1:0] RESET_PC  = 16'h0000,
   parameter logic [PcWidth-1:0] NOP_INSTR = NopInstr,
   parameter logic [4:0]         HALT_OPC  = HaltOpc
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall_i,
   input  logic               redirect_i,
   input  logic [PcWidth-1:0] redirectPC_i,
   output logic               imemRd_o,
   output logic [PcWidth-1:0] imemAddr_o,
   input  logic [PcWidth-1:0] imemData_i,
   input  logic               imemDone_i,
   output logic [PcWidth-1:0] instr_o,
   output logic               valid_o,
   output logic [PcWidth-1:0] pcPlus2_o,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]        fetchCount_o,
   output logic [31:0]        stallCycles_o,
`endif
   output logic               halted_o
);

   fetch_state_e       state_q, state_d;
   logic [PcWidth-1:0] pc_q, pc_d;
   logic [PcWidth-1:0] addr_q, addr_d;   // address of the request being drained
   logic [PcWidth-1:0] instr_q, instr_d;
   logic               valid_q, valid_d;
   logic [PcWidth-1:0] pc_plus2_q, pc_plus2_d;

   logic               skid_full, skid_load, skid_unload;
   logic [PcWidth-1:0] skid_instr, skid_pc_plus2;
   logic               req, accept, is_halt, if_free;
   logic [PcWidth-1:0] pc_inc;

   // Request, accept and next-state decode.
   always_comb begin
      pc_inc  = pc_q + 16'd2;
      if_free = !valid_q || !stall_i;
      is_halt = (imemData_i[15:11] == HALT_OPC);
      unique case (state_q)
         StIdle:          req = !skid_full && !redirect_i;
         StWait, StDrain: req = 1'b1;
         default:         req = 1'b0;
      endcase
      // Keep the request low while reset is held, even though the state reads IDLE.
      req        = req && rst_n;
      accept     = req && imemDone_i && !redirect_i && (state_q != StDrain);
      imemRd_o   = req;
      imemAddr_o = (state_q == StDrain) ? word_align(addr_q) : word_align(pc_q);

      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      if (redirect_i) begin
         pc_d    = word_align(redirectPC_i);
         addr_d  = imemAddr_o;
         state_d = (req && !imemDone_i) ? StDrain : StIdle;
      end else if (accept) begin
         pc_d    = pc_inc;
         state_d = is_halt ? StHalted : StIdle;
      end else if (req) begin
         if (state_q == StDrain) state_d = imemDone_i ? StIdle : StDrain;
         else                    state_d = StWait;
      end
   end

   // IF/ID register next-state and skid buffer control.
   always_comb begin
      instr_d     = instr_q;
      valid_d     = valid_q;
      pc_plus2_d  = pc_plus2_q;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      if (redirect_i) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end else if (if_free) begin
         if (skid_full) begin
            instr_d     = skid_instr;
            pc_plus2_d  = skid_pc_plus2;
            valid_d     = 1'b1;
            skid_unload = 1'b1;
         end else if (accept) begin
            instr_d    = imemData_i;
            pc_plus2_d = pc_inc;
            valid_d    = 1'b1;
         end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
      end else begin
         skid_load = accept;
      end
   end

   // State, PC and IF/ID registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         pc_q       <= word_align(RESET_PC);
         addr_q     <= word_align(RESET_PC);
         instr_q    <= NOP_INSTR;
         valid_q    <= 1'b0;
         pc_plus2_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         pc_plus2_q <= pc_plus2_d;
      end
   end

   fetch_skid_buf u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (skid_load),
      .unload_i   (skid_unload),
      .clear_i    (redirect_i),
      .instr_i    (imemData_i),
      .pc_plus2_i (pc_inc),
      .full_o     (skid_full),
      .instr_o    (skid_instr),
      .pc_plus2_o (skid_pc_plus2)
   );

   assign instr_o   = instr_q;
   assign valid_o   = valid_q;
   assign pcPlus2_o = pc_plus2_q;
   assign halted_o  = (state_q == StHalted);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, stall_cyc_q;

   // Saturating counters: accepted words, and cycles decode holds a valid word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         stall_cyc_q <= '0;
      end else begin
         if (accept && (fetch_cnt_q != '1))                 fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (valid_q && stall_i && (stall_cyc_q != '1))     stall_cyc_q <= stall_cyc_q + 32'd1;
      end
   end

   assign fetchCount_o  = fetch_cnt_q;
   assign stallCycles_o = stall_cyc_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: variable-latency memory model plus an in-order scoreboard.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, redirect;
   logic [15:0] redirect_pc;
   logic        imem_rd, imem_done;
   logic [15:0] imem_addr, imem_data;
   logic [15:0] instr, pc_plus2;
   logic        valid, halted;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count, stall_cycles;
`endif

   fetch_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_i      (stall),
      .redirect_i   (redirect),
      .redirectPC_i (redirect_pc),
      .imemRd_o     (imem_rd),
      .imemAddr_o   (imem_addr),
      .imemData_i   (imem_data),
      .imemDone_i   (imem_done),
      .instr_o      (instr),
      .valid_o      (valid),
      .pcPlus2_o    (pc_plus2),
`ifdef FETCH_PERF_CNT_EN
      .fetchCount_o (fetch_count),
      .stallCycles_o(stall_cycles),
`endif
      .halted_o     (halted)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory model: request completes in its lat-th cycle (lat=1 means same cycle).
   logic [15:0] mem [0:127];
   int unsigned lat = 1;
   int unsigned cnt;

   always_comb begin
      imem_done = imem_rd && ((cnt + 1) >= lat);
      imem_data = mem[imem_addr[7:1]];
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     cnt <= 0;
      else if (imem_rd && !imem_done) cnt <= cnt + 1;
      else                            cnt <= 0;
   end

   // Scoreboard: expected words pushed on completion, popped when decode consumes.
   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pp2;
   } exp_t;
   exp_t        sb_q[$];
   logic [15:0] exp_pc;
   logic        draining;
   logic        prev_wait;
   logic [15:0] prev_addr;

   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
         exp_pc    = 16'h0000;
         draining  = 1'b0;
         prev_wait = 1'b0;
      end else begin
         if (prev_wait) begin
            check_eq("rd_held", 32'(imem_rd), 32'd1);
            check_eq("addr_stable", 32'(imem_addr), 32'(prev_addr));
         end
         if (imem_rd) check_eq("addr_even", 32'(imem_addr[0]), 32'd0);
         if (valid && !stall && !redirect) begin
            if (sb_q.size() == 0) begin
               check_eq("unexpected_word", 32'(instr), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check_eq("instr", 32'(instr), 32'(e.instr));
               check_eq("pc_plus2", 32'(pc_plus2), 32'(e.pp2));
            end
         end
         if (redirect) begin
            sb_q.delete();
            draining = imem_rd && !imem_done;
            exp_pc   = redirect_pc & 16'hFFFE;
         end else if (imem_rd && imem_done) begin
            if (draining) begin
               draining = 1'b0;
            end else begin
               check_eq("fetch_addr", 32'(imem_addr), 32'(exp_pc));
               sb_q.push_back({mem[exp_pc[7:1]], 16'(exp_pc + 16'd2)});
               exp_pc = exp_pc + 16'd2;
            end
         end
         prev_wait = imem_rd && !imem_done;
         prev_addr = imem_addr;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_redirect(input logic [15:0] target);
      step();
      redirect    = 1'b1;
      redirect_pc = target;
      step();
      redirect    = 1'b0;
   endtask

   initial begin
      int n_valid, n_rd, guard;
      logic [15:0] old_addr;
      logic found;

      for (int i = 0; i < 128; i++) mem[i] = 16'(16'h4001 + i);
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;

      // Reset values.
      repeat (2) @(negedge clk);
      check_eq("rst_rd", 32'(imem_rd), 32'd0);
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_instr", 32'(instr), 32'h0800);
      check_eq("rst_pc_plus2", 32'(pc_plus2), 32'd0);
      check_eq("rst_halted", 32'(halted), 32'd0);

      // Zero-wait memory: back-to-back fetches, one-cycle IF/ID latency.
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("z_addr0", 32'(imem_addr), 32'h0);
      check_eq("z_rd0", 32'(imem_rd), 32'd1);
      check_eq("z_valid0", 32'(valid), 32'd0);
      @(negedge clk);
      check_eq("z_addr1", 32'(imem_addr), 32'h2);
      check_eq("z_valid1", 32'(valid), 32'd1);
      check_eq("z_instr1", 32'(instr), 32'h4001);
      check_eq("z_pp2_1", 32'(pc_plus2), 32'h2);
      @(negedge clk);
      check_eq("z_addr2", 32'(imem_addr), 32'h4);
      check_eq("z_instr2", 32'(instr), 32'h4002);
      check_eq("z_pp2_2", 32'(pc_plus2), 32'h4);

      // Three-cycle latency: one valid pulse per three cycles, request held throughout.
      step();
      lat = 3;
      repeat (3) @(negedge clk);
      n_valid = 0; n_rd = 0;
      repeat (12) begin
         @(negedge clk);
         if (valid)   n_valid++;
         if (imem_rd) n_rd++;
      end
      check_eq("lat3_valid_pulses", 32'(n_valid), 32'd4);
      check_eq("lat3_rd_cycles", 32'(n_rd), 32'd12);

      // Decode stall: IF/ID holds, skid fills, requests stop, then in-order release.
      step();
      lat = 1;
      repeat (4) step();
      stall = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_eq("stall_valid", 32'(valid), 32'd1);
         if (c > 0) check_eq("stall_rd_off", 32'(imem_rd), 32'd0);
      end
      step();
      stall = 1'b0;
      repeat (8) @(negedge clk);

      // Redirect while WAIT: flush, drain old request, refetch at target.
      step();
      lat = 3;
      found = 1'b0;
      for (guard = 0; guard < 20 && !found; guard++) begin
         @(negedge clk);
         found = imem_rd && (cnt == 0);
      end
      check_eq("wait_reached", 32'(found), 32'd1);
      step();
      redirect    = 1'b1;
      redirect_pc = 16'h0040;
      @(negedge clk);
      old_addr = imem_addr;
      check_eq("redir_rd", 32'(imem_rd), 32'd1);
      step();
      redirect = 1'b0;
      @(negedge clk);
      check_eq("redir_valid", 32'(valid), 32'd0);
      check_eq("redir_instr", 32'(instr), 32'h0800);
      check_eq("drain_addr", 32'(imem_addr), 32'(old_addr));
      found = 1'b0;
      for (guard = 0; guard < 10 && !found; guard++) begin
         @(negedge clk);
         found = imem_rd && (imem_addr == 16'h0040);
      end
      check_eq("refetch_0040", 32'(found), 32'd1);
      repeat (6) @(negedge clk);

      // HALT at address 6: delivered, then no more requests until redirect.
      mem[3] = 16'h0000;
      lat = 1;
      do_redirect(16'h0000);
      found = 1'b0;
      for (guard = 0; guard < 20 && !found; guard++) begin
         @(negedge clk);
         found = halted;
      end
      check_eq("halted_seen", 32'(found), 32'd1);
      check_eq("halt_valid", 32'(valid), 32'd1);
      check_eq("halt_instr", 32'(instr), 32'h0000);
      check_eq("halt_pp2", 32'(pc_plus2), 32'h0008);
      repeat (3) begin
         @(negedge clk);
         check_eq("halt_rd_off", 32'(imem_rd), 32'd0);
         check_eq("halt_hold", 32'(halted), 32'd1);
         check_eq("halt_empty", 32'(valid), 32'd0);
      end
      mem[3] = 16'h4004;
      do_redirect(16'h0010);
      @(negedge clk);
      check_eq("unhalt", 32'(halted), 32'd0);
      check_eq("unhalt_rd", 32'(imem_rd), 32'd1);
      check_eq("unhalt_addr", 32'(imem_addr), 32'h0010);
      @(negedge clk);
      check_eq("unhalt_instr", 32'(instr), 32'h4009);
      check_eq("unhalt_pp2", 32'(pc_plus2), 32'h0012);

      // Odd redirect target is forced even.
      do_redirect(16'h0021);
      @(negedge clk);
      check_eq("odd_redir_addr", 32'(imem_addr), 32'h0020);
      repeat (4) @(negedge clk);

      // Reset in the middle of a WAIT.
      step();
      lat = 3;
      found = 1'b0;
      for (guard = 0; guard < 20 && !found; guard++) begin
         @(negedge clk);
         found = imem_rd && (cnt == 0);
      end
      check_eq("wait_reached2", 32'(found), 32'd1);
      step();
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_rd", 32'(imem_rd), 32'd0);
      check_eq("mid_rst_valid", 32'(valid), 32'd0);
      check_eq("mid_rst_instr", 32'(instr), 32'h0800);
      check_eq("mid_rst_pp2", 32'(pc_plus2), 32'd0);
      check_eq("mid_rst_halted", 32'(halted), 32'd0);
      @(negedge clk);
      step();
      rst_n = 1'b1;
      lat   = 1;
      @(negedge clk);
      check_eq("post_rst_rd", 32'(imem_rd), 32'd1);
      check_eq("post_rst_addr", 32'(imem_addr), 32'h0000);
      repeat (6) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
